// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, 16-entry BTB with 2-bit counters, and IF/ID pipeline register.
// Redirects from EX take priority over stalls, and stalls take priority over BTB predictions.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        PcWrite,
  input  logic        IFID_Write,
  input  logic        Bubble,
  input  logic [31:0] EX_RedirectPC,
  input  logic        EX_Update,
  input  logic [31:0] EX_PC,
  input  logic        EX_Taken,
  input  logic [31:0] EX_Target,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PC4,
  output logic [1:0]  IFID_pcSel
);

  localparam int unsigned BtbEntries = 16;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [1:0]  ifid_sel_q, ifid_sel_d;

  logic [BtbEntries-1:0] btb_valid_q, btb_valid_d;
  logic [25:0]           btb_tag_q    [BtbEntries];
  logic [25:0]           btb_tag_d    [BtbEntries];
  logic [31:0]           btb_target_q [BtbEntries];
  logic [31:0]           btb_target_d [BtbEntries];
  logic [1:0]            btb_ctr_q    [BtbEntries];
  logic [1:0]            btb_ctr_d    [BtbEntries];

  logic [3:0]  fetch_idx;
  logic        fetch_hit;
  logic        pred_taken;
  logic [1:0]  pred_sel;
  logic [3:0]  ex_idx;
  logic        ex_hit;
  logic [1:0]  unused_ex_pc_lsb;

  assign unused_ex_pc_lsb = EX_PC[1:0];
  assign pc_plus4         = pc_q + 32'd4;

  // BTB lookup for the current fetch address (reads pre-update contents)
  always_comb begin
    fetch_idx  = pc_q[5:2];
    fetch_hit  = btb_valid_q[fetch_idx] && (btb_tag_q[fetch_idx] == pc_q[31:6]);
    pred_taken = fetch_hit && btb_ctr_q[fetch_idx][1];
    pred_sel   = pred_taken ? 2'b01 : 2'b00;
  end

  // Next-PC selection: redirect, hold, predicted target, fall-through
  always_comb begin
    pc_d = pc_plus4;
    if (Bubble) begin
      pc_d = EX_RedirectPC;
    end else if (!PcWrite) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = btb_target_q[fetch_idx];
    end else begin
      pc_d = pc_plus4;
    end
  end

  // IF/ID next state: flush on redirect, hold on stall, otherwise capture the fetch
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_sel_d   = ifid_sel_q;
    if (Bubble) begin
      ifid_instr_d = 32'h0000_0000;
      ifid_pc4_d   = 32'h0000_0000;
      ifid_sel_d   = 2'b00;
    end else if (IFID_Write) begin
      ifid_instr_d = Imem_Data;
      ifid_pc4_d   = pc_plus4;
      ifid_sel_d   = pred_sel;
    end else begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_sel_d   = ifid_sel_q;
    end
  end

  // BTB training from the resolved branch in EX; a not-taken miss leaves the table alone
  always_comb begin
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    btb_ctr_d    = btb_ctr_q;
    ex_idx       = EX_PC[5:2];
    ex_hit       = btb_valid_q[ex_idx] && (btb_tag_q[ex_idx] == EX_PC[31:6]);
    if (EX_Update) begin
      if (ex_hit) begin
        if (EX_Taken) begin
          btb_ctr_d[ex_idx]    = ctr_inc(btb_ctr_q[ex_idx]);
          btb_target_d[ex_idx] = EX_Target;
        end else begin
          btb_ctr_d[ex_idx]    = ctr_dec(btb_ctr_q[ex_idx]);
        end
      end else if (EX_Taken) begin
        btb_valid_d[ex_idx]  = 1'b1;
        btb_tag_d[ex_idx]    = EX_PC[31:6];
        btb_target_d[ex_idx] = EX_Target;
        btb_ctr_d[ex_idx]    = 2'b10;
      end else begin
        btb_valid_d = btb_valid_q;
      end
    end else begin
      btb_valid_d = btb_valid_q;
    end
  end

  // State registers; reset overrides redirect, update and hold inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= 32'h0000_0000;
      ifid_instr_q <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_sel_q   <= 2'b00;
      btb_valid_q  <= '0;
      for (int i = 0; i < BtbEntries; i++) begin
        btb_tag_q[i]    <= 26'd0;
        btb_target_q[i] <= 32'd0;
        btb_ctr_q[i]    <= 2'b00;
      end
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_sel_q   <= ifid_sel_d;
      btb_valid_q  <= btb_valid_d;
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
      btb_ctr_q    <= btb_ctr_d;
    end
  end

  assign Imem_Addr  = pc_q;
  assign IFID_Instr = ifid_instr_q;
  assign IFID_PC4   = ifid_pc4_q;
  assign IFID_pcSel = ifid_sel_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit: per-cycle vectors check Imem_Addr directly and
// push the expected IF/ID contents to a queue that is compared one cycle later.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, ifid_write, bubble, ex_update, ex_taken;
  logic [31:0] ex_redirect_pc, ex_pc, ex_target;
  logic [31:0] imem_addr, imem_data, ifid_instr, ifid_pc4;
  logic [1:0]  ifid_pcsel;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  assign imem_data = imem_fn(imem_addr);

  fetch_unit dut (
    .clk(clk), .rst(rst), .PcWrite(pc_write), .IFID_Write(ifid_write), .Bubble(bubble),
    .EX_RedirectPC(ex_redirect_pc), .EX_Update(ex_update), .EX_PC(ex_pc),
    .EX_Taken(ex_taken), .EX_Target(ex_target), .Imem_Addr(imem_addr),
    .Imem_Data(imem_data), .IFID_Instr(ifid_instr), .IFID_PC4(ifid_pc4),
    .IFID_pcSel(ifid_pcsel)
  );

  typedef struct {
    logic        pw, iw, bub;
    logic [31:0] redir;
    logic        upd;
    logic [31:0] epc;
    logic        etk;
    logic [31:0] etg;
    logic [31:0] exp_addr;
    logic [1:0]  exp_sel;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [1:0]  sel;
  } ifid_t;

  vec_t  vecs [34];
  ifid_t sb [$];
  ifid_t last_exp;
  int    checks = 0;
  int    failures = 0;

  function automatic vec_t mk(input logic pw, input logic iw, input logic bub,
                              input logic [31:0] redir, input logic upd,
                              input logic [31:0] epc, input logic etk,
                              input logic [31:0] etg, input logic [31:0] addr,
                              input logic [1:0] sel);
    vec_t v;
    v.pw = pw; v.iw = iw; v.bub = bub; v.redir = redir; v.upd = upd;
    v.epc = epc; v.etk = etk; v.etg = etg; v.exp_addr = addr; v.exp_sel = sel;
    return v;
  endfunction

  function automatic vec_t n(input logic [31:0] addr, input logic [1:0] sel);
    return mk(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, addr, sel);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pop_check(input int id);
    ifid_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("ifid_instr[%0d]", id), ifid_instr, e.instr);
      check($sformatf("ifid_pc4[%0d]", id), ifid_pc4, e.pc4);
      check($sformatf("ifid_pcsel[%0d]", id), {30'd0, ifid_pcsel}, {30'd0, e.sel});
    end
  endtask

  // Called just after a falling edge: drive, check, predict IF/ID, advance one cycle.
  task automatic step(input vec_t v, input int id);
    ifid_t e;
    pc_write = v.pw; ifid_write = v.iw; bubble = v.bub; ex_redirect_pc = v.redir;
    ex_update = v.upd; ex_pc = v.epc; ex_taken = v.etk; ex_target = v.etg;
    #1;
    check($sformatf("imem_addr[%0d]", id), imem_addr, v.exp_addr);
    pop_check(id);
    if (v.bub) e = '0;
    else if (!v.iw) e = last_exp;
    else e = '{instr: imem_fn(v.exp_addr), pc4: v.exp_addr + 32'd4, sel: v.exp_sel};
    last_exp = e;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = n(32'h0, 2'b00);
    vecs[1]  = n(32'h4, 2'b00);
    vecs[2]  = n(32'h8, 2'b00);
    vecs[3]  = n(32'hC, 2'b00);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h10, 2'b00);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h10, 2'b00);
    vecs[6]  = n(32'h10, 2'b00);
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h20, 1'b1, 32'h80, 32'h14, 2'b00);
    vecs[8]  = n(32'h18, 2'b00);
    vecs[9]  = n(32'h1C, 2'b00);
    vecs[10] = n(32'h20, 2'b01);
    vecs[11] = mk(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0, 32'h0, 32'h80, 2'b00);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h90, 32'h20, 2'b00);
    vecs[13] = mk(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0, 32'h0, 32'h24, 2'b00);
    vecs[14] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 32'h0, 32'h20, 2'b00);
    vecs[15] = mk(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0, 32'h0, 32'h24, 2'b00);
    vecs[16] = n(32'h20, 2'b00);
    vecs[17] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h90, 32'h24, 2'b00);
    vecs[18] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h90, 32'h28, 2'b00);
    vecs[19] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h90, 32'h2C, 2'b00);
    vecs[20] = mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h90, 32'h30, 2'b00);
    vecs[21] = mk(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h20, 1'b0, 32'h0, 32'h34, 2'b00);
    vecs[22] = n(32'h20, 2'b01);
    vecs[23] = mk(1'b1, 1'b1, 1'b1, 32'h60, 1'b0, 32'h0, 1'b0, 32'h0, 32'h90, 2'b00);
    vecs[24] = n(32'h60, 2'b00);
    vecs[25] = mk(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 32'h64, 2'b00);
    vecs[26] = n(32'h200, 2'b00);
    vecs[27] = mk(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h1A0, 1'b0, 32'h0, 32'h204, 2'b00);
    vecs[28] = n(32'h20, 2'b01);
    vecs[29] = mk(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0, 32'h0, 32'h90, 2'b00);
    vecs[30] = n(32'hFFFF_FFF8, 2'b00);
    vecs[31] = n(32'hFFFF_FFFC, 2'b00);
    vecs[32] = n(32'h0, 2'b00);
    vecs[33] = n(32'h4, 2'b00);

    rst = 1'b1; pc_write = 1'b1; ifid_write = 1'b1; bubble = 1'b0; ex_update = 1'b0;
    ex_taken = 1'b0; ex_redirect_pc = 32'd0; ex_pc = 32'd0; ex_target = 32'd0;
    last_exp = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_addr", imem_addr, 32'h0);
    check("reset_instr", ifid_instr, 32'h0);
    check("reset_pc4", ifid_pc4, 32'h0);
    check("reset_pcsel", {30'd0, ifid_pcsel}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 34; i++) step(vecs[i], i);

    // Reset in the same cycle as a redirect and a taken BTB update must win over both
    rst = 1'b1; bubble = 1'b1; ex_redirect_pc = 32'h300; ex_update = 1'b1;
    ex_pc = 32'h20; ex_taken = 1'b1; ex_target = 32'h44; pc_write = 1'b0; ifid_write = 1'b0;
    @(negedge clk);
    rst = 1'b0; bubble = 1'b0; ex_update = 1'b0; pc_write = 1'b1; ifid_write = 1'b1;
    #1;
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_instr", ifid_instr, 32'h0);
    check("midrst_pc4", ifid_pc4, 32'h0);
    check("midrst_pcsel", {30'd0, ifid_pcsel}, 32'h0);
    sb.delete();
    last_exp = '0;
    step(mk(1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00), 100);
    step(n(32'h20, 2'b00), 101);
    step(n(32'h24, 2'b00), 102);
    #1;
    pop_check(103);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
